fetch_buffered: RTL

Next-generation instruction fetch stage for the in-order RISC-V pipeline.
- Decouples PC generation from decode with a parametrised fetch queue (FQ).
- Talks to the instruction cache through a variable-latency request/response handshake, with one request outstanding.
- Handles trap and branch/jump redirects using an epoch bit, so stale cache responses are discarded without stalling.

---
 rtl/fetch_pkg.sv | 49 ++++
 rtl/fetch_buffered_if.sv | 44 ++++
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_buffered.sv | 110 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the buffered fetch stage.
// Holds queue entry layout and redirect priority.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
  } fq_entry_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_TRAP
  } redir_e;

  typedef enum logic {
    FE_IDLE,
    FE_WAIT
  } fe_state_e;

  function automatic redir_e redir_sel(
    input logic trap_v,
    input logic redir_v
  );
    redir_e s;
    unique case (1'b1)
      trap_v:             s = RD_TRAP;
      redir_v & ~trap_v:  s = RD_BRANCH;
      default:            s = RD_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [XLEN-1:0] redir_target(
    input redir_e          sel,
    input logic [XLEN-1:0] mtvec,
    input logic [XLEN-1:0] redir_pc
  );
    logic [XLEN-1:0] t;
    t = (sel == RD_TRAP) ? mtvec : redir_pc;
    return {t[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffered_if.sv
// Cache request/response and decode handshake bundle
// seen from the fetch stage (master) and its peers (slave).
interface fetch_buffered_if;
  import fetch_pkg::*;

  logic            ic_req_v;
  logic [XLEN-1:0] ic_req_pc;
  logic            ic_req_rdy;
  logic            ic_resp_v;
  logic [ILEN-1:0] ic_resp_ir;

  logic            de_v;
  logic [ILEN-1:0] de_ir;
  logic [XLEN-1:0] de_pc;
  logic [XLEN-1:0] de_npc;
  logic            de_rdy;

  modport master (
    output ic_req_v,
    output ic_req_pc,
    input  ic_req_rdy,
    input  ic_resp_v,
    input  ic_resp_ir,
    output de_v,
    output de_ir,
    output de_pc,
    output de_npc,
    input  de_rdy
  );

  modport slave (
    input  ic_req_v,
    input  ic_req_pc,
    output ic_req_rdy,
    output ic_resp_v,
    output ic_resp_ir,
    input  de_v,
    input  de_ir,
    input  de_pc,
    input  de_npc,
    output de_rdy
  );

endinterface

// File: rtl/fetch_queue.sv
// Registered FIFO of fetched {pc, ir} entries.
// Flush wins over a simultaneous push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fq_entry_t                wdata,
  output logic [$clog2(DEPTH):0]   count,
  output fq_entry_t                head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < CW'(DEPTH)) | do_pop);

  always_ff @(posedge CLK) begin
    if (reset | flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push & ~flush & ~reset)
      mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffered.sv
// Fetch stage: PC generation, one-outstanding icache
// handshake, epoch-tagged redirects and a fetch queue.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            redir_v,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            trap_v,
  input  logic [XLEN-1:0] mtvec,
  input  logic            br_stall,
  fetch_buffered_if.master fe
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  fe_state_e       state;
  fe_state_e       state_nx;
  redir_e          rsel;
  logic            redirect;
  logic [XLEN-1:0] fe_pc;
  logic [XLEN-1:0] req_pc;
  logic            epoch;
  logic            req_epoch;
  logic            accept;
  logic            resp;
  logic            push;
  logic            pop;
  logic            empty;
  logic [CW-1:0]   count;
  fq_entry_t       head;
  fq_entry_t       wdata;

  assign rsel     = redir_sel(trap_v, redir_v);
  assign redirect = (rsel != RD_NONE);
  assign accept   = fe.ic_req_v & fe.ic_req_rdy;
  assign resp     = fe.ic_resp_v & (state == FE_WAIT);
  assign push     = resp & (req_epoch == epoch) & ~redirect;
  assign empty    = (count == '0);
  assign pop      = ~empty & ~br_stall & fe.de_rdy & ~redirect;
  assign wdata    = '{pc: req_pc, ir: fe.ic_resp_ir};

  always_ff @(posedge CLK) begin
    if (reset) state <= FE_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FE_IDLE: if (accept) state_nx = FE_WAIT;
      FE_WAIT: if (resp)   state_nx = FE_IDLE;
      default:             state_nx = FE_IDLE;
    endcase
  end

  always_comb begin
    fe.ic_req_v  = 1'b0;
    fe.ic_req_pc = fe_pc;
    fe.de_v      = 1'b0;
    fe.de_ir     = RV_NOP;
    fe.de_pc     = '0;
    fe.de_npc    = '0;
    if (~reset && state == FE_IDLE &&
        count < CW'(FQ_DEPTH) &&
        ~br_stall && ~redirect)
      fe.ic_req_v = 1'b1;
    if (~empty) begin
      fe.de_v   = ~br_stall;
      fe.de_ir  = head.ir;
      fe.de_pc  = head.pc;
      fe.de_npc = head.pc + XLEN'(4);
    end
  end

  // A redirect never coincides with an accept: ic_req_v is masked.
  always_ff @(posedge CLK) begin
    if (reset) begin
      fe_pc     <= RESET_PC;
      epoch     <= 1'b0;
      req_epoch <= 1'b0;
      req_pc    <= '0;
    end else if (redirect) begin
      fe_pc <= redir_target(rsel, mtvec, redir_pc);
      epoch <= ~epoch;
    end else if (accept) begin
      fe_pc     <= fe_pc + XLEN'(4);
      req_epoch <= epoch;
      req_pc    <= fe_pc;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

endmodule
